switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer.sv | 148 ++++++++++++++
 tb/tb_switch_debouncer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Conditions one raw, asynchronous switch or push-button pin into a clean,
//   glitch-free level for downstream Moore FSMs. The pin first passes through
//   an N-flop synchronizer. A 4-state debounce FSM with a stability counter
//   then accepts a new level only after DEBOUNCE_CYCLES consecutive
//   synchronized samples at that level.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive samples needed to accept a change (>= 2)
//   SYNC_STAGES     : synchronizer depth (>= 2)
//   RESET_LEVEL     : level assumed for the pin and driven on sw_out in reset
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   sw_in      : raw pin, asynchronous to clk
//   sw_out     : debounced level (registered)
//   rise_pulse : one-cycle pulse when sw_out goes 0->1 (registered)
//   fall_pulse : one-cycle pulse when sw_out goes 1->0 (registered)

module switch_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 100000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_e;

  localparam state_e RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sw_out_q, sw_out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchronizer shift chain; the oldest flop is the only sample the FSM sees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      sw_out_q <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_out_q <= sw_out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // Next-state logic. The counter holds the number of consecutive samples
  // already seen at the new level; it never advances past CNT_LAST because
  // reaching CNT_LAST with another matching sample commits the change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up
  // exactly with the state register. Pulses fire only on a committed change,
  // never on reset entry or on a rejected glitch.
  always_comb begin
    sw_out_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
    rise_d   = (state_q == WAIT_HIGH) && (state_d == STABLE_HIGH);
    fall_d   = (state_q == WAIT_LOW)  && (state_d == STABLE_LOW);
  end

  assign sw_out     = sw_out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Scoreboard bench for switch_debouncer. Two instances with a short
//   debounce window: dutA resets low, dutB resets high. Stimulus pushes the
//   hand-computed edge number and direction of every pulse it expects; a
//   negedge monitor pops one entry per observed pulse and compares.

module tb_switch_debouncer;

  localparam int DC   = 4;
  localparam int SS   = 2;
  localparam int HALF = DC + 2;

  typedef struct {
    bit isRise;
    int edgeNum;
  } pulse_t;

  logic clock = 1'b0;
  logic resetA, swA, outA, riseA, fallA;
  logic resetB, swB, outB, riseB, fallB;

  int edgeCount   = 0;
  int testsRun    = 0;
  int testsFailed = 0;

  pulse_t expA[$];
  pulse_t expB[$];

  always #5 clock = ~clock;

  always @(posedge clock) edgeCount++;

  switch_debouncer #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .RESET_LEVEL(1'b0)) dutA (
    .clk(clock), .reset(resetA), .sw_in(swA),
    .sw_out(outA), .rise_pulse(riseA), .fall_pulse(fallA)
  );

  switch_debouncer #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .RESET_LEVEL(1'b1)) dutB (
    .clk(clock), .reset(resetB), .sw_in(swB),
    .sw_out(outB), .rise_pulse(riseB), .fall_pulse(fallB)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic pulse_t mkPulse(input bit isRise, input int edgeNum);
    pulse_t p;
    p.isRise  = isRise;
    p.edgeNum = edgeNum;
    return p;
  endfunction

  task automatic comparePulse(input string who, input logic r, input logic f,
                              input logic lvl, input pulse_t e);
    checkOutput({who, " pulse edge"}, edgeCount, e.edgeNum);
    checkOutput({who, " rise_pulse"}, int'(r), int'(e.isRise));
    checkOutput({who, " fall_pulse"}, int'(f), int'(!e.isRise));
    checkOutput({who, " sw_out at pulse"}, int'(lvl), int'(e.isRise));
  endtask

  // Monitor: every pulse seen on either DUT must match the oldest expectation.
  always @(negedge clock) begin
    pulse_t e;
    if (riseA || fallA) begin
      if (expA.size() == 0) begin
        checkOutput("A unexpected pulse at edge", edgeCount, -1);
      end else begin
        e = expA.pop_front();
        comparePulse("A", riseA, fallA, outA, e);
      end
    end
    if (riseB || fallB) begin
      if (expB.size() == 0) begin
        checkOutput("B unexpected pulse at edge", edgeCount, -1);
      end else begin
        e = expB.pop_front();
        comparePulse("B", riseB, fallB, outB, e);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives n bits MSB first, one per negedge; k is the first edge sampling them.
  task automatic applyStimulus(input bit isB, input logic [15:0] bits, input int n,
                               output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (isB) swB = bits[n-1-i];
      else     swA = bits[n-1-i];
      if (i == 0) k = edgeCount + 1;
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    repeat (5000) @(posedge clock);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL watchdog: edge %0d, limit 5000", edgeCount);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    int k;
    resetA = 1'b1; swA = 1'b0;
    resetB = 1'b1; swB = 1'b1;

    // Reset state on both instances.
    waitCycles(3);
    checkOutput("A sw_out in reset", int'(outA), 0);
    checkOutput("A rise in reset", int'(riseA), 0);
    checkOutput("A fall in reset", int'(fallA), 0);
    checkOutput("B sw_out in reset", int'(outB), 1);
    resetA = 1'b0;
    resetB = 1'b0;
    waitCycles(1);
    checkOutput("B sw_out after release", int'(outB), 1);
    waitCycles(20);
    checkOutput("A sw_out idle low", int'(outA), 0);
    checkOutput("B sw_out idle high", int'(outB), 1);

    // Reset while WAIT_HIGH holds cnt=2; the count must restart from scratch.
    applyStimulus(1'b0, 16'h0001, 1, k);
    waitCycles(4);
    resetA = 1'b1;
    waitCycles(1);
    checkOutput("A sw_out during mid reset", int'(outA), 0);
    resetA = 1'b0;
    k = edgeCount + 1;
    expA.push_back(mkPulse(1'b1, k + 5));
    waitCycles(10);
    checkOutput("A sw_out after post-reset rise", int'(outA), 1);

    // Fall from stable high, then a clean rise and fall.
    applyStimulus(1'b0, 16'h0000, 1, k);
    expA.push_back(mkPulse(1'b0, k + 5));
    waitCycles(10);
    checkOutput("A sw_out after fall", int'(outA), 0);
    applyStimulus(1'b0, 16'h0001, 1, k);
    expA.push_back(mkPulse(1'b1, k + 5));
    waitCycles(10);
    checkOutput("A sw_out after rise", int'(outA), 1);
    applyStimulus(1'b0, 16'h0000, 1, k);
    expA.push_back(mkPulse(1'b0, k + 5));
    waitCycles(10);

    // Three-sample high glitch is rejected.
    applyStimulus(1'b0, 16'b1110, 4, k);
    waitCycles(15);
    checkOutput("A sw_out after high glitch", int'(outA), 0);

    // Exactly DC samples high is accepted; immediate return low fires DC later.
    applyStimulus(1'b0, 16'b11110, 5, k);
    expA.push_back(mkPulse(1'b1, k + 5));
    expA.push_back(mkPulse(1'b0, k + 9));
    waitCycles(15);
    checkOutput("A sw_out after min-width pair", int'(outA), 0);

    // Bounce pattern: only the final run of four ones is accepted.
    applyStimulus(1'b0, 16'b101101111, 9, k);
    expA.push_back(mkPulse(1'b1, k + 10));
    waitCycles(12);
    checkOutput("A sw_out after bounce", int'(outA), 1);

    // Three-sample low glitch from high is rejected, then a real fall.
    applyStimulus(1'b0, 16'b0001, 4, k);
    waitCycles(15);
    checkOutput("A sw_out after low glitch", int'(outA), 1);
    applyStimulus(1'b0, 16'h0000, 1, k);
    expA.push_back(mkPulse(1'b0, k + 5));
    waitCycles(10);
    checkOutput("A sw_out final", int'(outA), 0);

    // dutB: toggle with period 2*DC+4 -> alternating one-cycle pulses.
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b1, (t % 2 == 0) ? 16'h0000 : 16'h0001, 1, k);
      expB.push_back(mkPulse((t % 2) == 1, k + 5));
      waitCycles(HALF - 1);
    end
    waitCycles(10);
    checkOutput("B sw_out after toggles", int'(outB), 1);

    checkOutput("A pending expected pulses", expA.size(), 0);
    checkOutput("B pending expected pulses", expB.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
